// File: rtl/up_bus_responder_if.sv
// Signals between the uP pin handshake, the responder and the internal register bus.
// The slave modport is the responder; the master modport is the uP pins plus the register file.
interface up_bus_if;
  logic        uP_start;
  logic        uP_handshake_1;
  logic [7:0]  uP_data_out;
  logic        uP_handshake_2;
  logic [7:0]  uP_data_in;
  logic        uP_ack;
  logic [7:0]  reg_address;
  logic [31:0] reg_write_data;
  logic        reg_write;
  logic        reg_read;
  logic [31:0] reg_read_data;

  modport slave (
    input  uP_start, uP_handshake_1, uP_data_out, reg_read_data,
    output uP_handshake_2, uP_data_in, uP_ack,
    output reg_address, reg_write_data, reg_write, reg_read
  );

  modport master (
    output uP_start, uP_handshake_1, uP_data_out, reg_read_data,
    input  uP_handshake_2, uP_data_in, uP_ack,
    input  reg_address, reg_write_data, reg_write, reg_read
  );
endinterface

// File: rtl/up_bus_responder.sv
// Byte-wide 4-phase uP handshake responder: turns 6-byte command packets into
// single-cycle register-bus write/read strobes and returns read data plus a status byte.
module up_bus_responder #(
  parameter int         NOS_REGISTERS = 32,
  parameter logic [7:0] CMD_WRITE     = 8'd1,
  parameter logic [7:0] CMD_READ      = 8'd2,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic    clk,
  input  logic    reset,
  up_bus_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_REG, WR_DATA, DO_WRITE, DO_READ, RD_DATA, DONE
  } state_t;

  localparam logic [8:0] ADDR_LIMIT = 9'(NOS_REGISTERS);

  logic [SYNC_STAGES-1:0] start_sync_q;
  logic [SYNC_STAGES-1:0] hs1_sync_q;
  logic                   s_start;
  logic                   s_hs1;

  state_t      state_q,    state_d;
  logic [1:0]  cnt_q,      cnt_d;
  logic        h2_q,       h2_d;
  logic [7:0]  din_q,      din_d;
  logic        ack_q,      ack_d;
  logic [7:0]  addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic        wr_q,       wr_d;
  logic        rd_q,       rd_d;
  logic [31:0] rdata_q,    rdata_d;
  logic [7:0]  status_q,   status_d;
  logic        cmd_rd_q,   cmd_rd_d;

  logic       in_handshake;
  logic       hs_rise;
  logic       hs_fall;
  logic [7:0] byte_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_sync_q <= '0;
      hs1_sync_q   <= '0;
    end else begin
      start_sync_q[0] <= bus.uP_start;
      hs1_sync_q[0]   <= bus.uP_handshake_1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        start_sync_q[i] <= start_sync_q[i-1];
        hs1_sync_q[i]   <= hs1_sync_q[i-1];
      end
    end
  end

  assign s_start = start_sync_q[SYNC_STAGES-1];
  assign s_hs1   = hs1_sync_q[SYNC_STAGES-1];
  assign byte_in = bus.uP_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      h2_q     <= 1'b0;
      din_q    <= 8'h00;
      ack_q    <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 32'h0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rdata_q  <= 32'h0;
      status_q <= 8'h00;
      cmd_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      h2_q     <= h2_d;
      din_q    <= din_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      cmd_rd_q <= cmd_rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    h2_d     = h2_q;
    din_d    = din_q;
    ack_d    = ack_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    rdata_d  = rdata_q;
    status_d = status_q;
    cmd_rd_d = cmd_rd_q;
    hs_rise  = 1'b0;
    hs_fall  = 1'b0;

    // One shared 4-phase engine: a byte is taken on the h2 rise and completes on the h2 fall.
    in_handshake = (state_q == GET_CMD) || (state_q == GET_REG) ||
                   (state_q == WR_DATA) || (state_q == RD_DATA);
    if (in_handshake) begin
      if (!h2_q && s_hs1) begin
        h2_d    = 1'b1;
        hs_rise = 1'b1;
      end else if (h2_q && !s_hs1) begin
        h2_d    = 1'b0;
        hs_fall = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        din_d = 8'h00;
        ack_d = 1'b0;
        if (s_start) begin
          state_d  = GET_CMD;
          cnt_d    = 2'd0;
          status_d = 8'h00;
          cmd_rd_d = 1'b0;
        end
      end

      GET_CMD: begin
        if (hs_rise) begin
          if (byte_in == CMD_WRITE) begin
            cmd_rd_d = 1'b0;
          end else if (byte_in == CMD_READ) begin
            cmd_rd_d = 1'b1;
          end else begin
            cmd_rd_d = 1'b0;
            status_d = 8'h01;
          end
        end
        if (hs_fall) begin
          state_d = GET_REG;
          cnt_d   = 2'd0;
        end
      end

      GET_REG: begin
        if (hs_rise) begin
          addr_d = byte_in;
          if ((status_q == 8'h00) && ({1'b0, byte_in} >= ADDR_LIMIT)) begin
            status_d = 8'h02;
          end
        end
        if (hs_fall) begin
          state_d = cmd_rd_q ? DO_READ : WR_DATA;
          cnt_d   = 2'd0;
        end
      end

      WR_DATA: begin
        if (hs_rise) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = byte_in;
        end
        if (hs_fall) begin
          if (cnt_q == 2'd3) begin
            state_d = DO_WRITE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      DO_WRITE: begin
        wr_d    = (status_q == 8'h00);
        state_d = DONE;
        cnt_d   = 2'd0;
      end

      // cnt 0 issues the strobe, cnt 1 is the strobe cycle, cnt 2 has read data valid.
      DO_READ: begin
        case (cnt_q)
          2'd0: begin
            rd_d  = (status_q == 8'h00);
            cnt_d = 2'd1;
          end
          2'd1: begin
            cnt_d = 2'd2;
          end
          default: begin
            rdata_d = (status_q == 8'h00) ? bus.reg_read_data : 32'h0;
            state_d = RD_DATA;
            cnt_d   = 2'd0;
          end
        endcase
      end

      RD_DATA: begin
        if (hs_rise) begin
          din_d = rdata_q[{cnt_q, 3'b000} +: 8];
        end
        if (hs_fall) begin
          din_d = 8'h00;
          if (cnt_q == 2'd3) begin
            state_d = DONE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      DONE: begin
        ack_d = 1'b1;
        din_d = status_q;
        if (!s_start) begin
          ack_d   = 1'b0;
          din_d   = 8'h00;
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    // Losing the frame mid-packet drops everything that has not already been strobed.
    if ((state_q != IDLE) && (state_q != DONE) && !s_start) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      h2_d    = 1'b0;
      din_d   = 8'h00;
      ack_d   = 1'b0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
    end
  end

  assign bus.uP_handshake_2 = h2_q;
  assign bus.uP_data_in     = din_q;
  assign bus.uP_ack         = ack_q;
  assign bus.reg_address    = addr_q;
  assign bus.reg_write_data = wdata_q;
  assign bus.reg_write      = wr_q;
  assign bus.reg_read       = rd_q;

endmodule

// File: tb/tb_up_bus_responder.sv
// Drives uP packets through the responder and checks strobes, returned bytes and status
// against a packet-level model of the register file.
module tb_up_bus_responder;

  localparam int NOS  = 32;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  up_bus_if bus ();

  up_bus_responder #(
    .NOS_REGISTERS(NOS),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int max_lat = 0;
  int pkt_no = 0;

  // Environment register file: answers strobes, read data valid the cycle after reg_read.
  logic [31:0] regfile [0:255];
  logic [31:0] rd_data_r;
  logic        init_done = 1'b0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          both_high = 0;
  logic [7:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  assign bus.reg_read_data = rd_data_r;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) regfile[i] <= (i == 5) ? 32'h12345678 : 32'h0;
      init_done <= 1'b1;
    end
    if (reset) rd_data_r <= 32'h0;
    else if (bus.reg_read) rd_data_r <= regfile[bus.reg_address];
    if (bus.reg_write) begin
      regfile[bus.reg_address] <= bus.reg_write_data;
      wr_count     <= wr_count + 1;
      last_wr_addr <= bus.reg_address;
      last_wr_data <= bus.reg_write_data;
    end
    if (bus.reg_read) rd_count <= rd_count + 1;
    if (bus.reg_write && bus.reg_read) both_high <= both_high + 1;
  end

  // Reference model: register contents as the uP should see them.
  logic [31:0] exp_mem [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_h2(input logic v, output int lat);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.uP_handshake_2 === v) lat = n;
    end
    check(v ? "h2_rise_wait" : "h2_fall_wait", 32'(lat != 0), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lat;
    bus.uP_data_out    = b;
    bus.uP_handshake_1 = 1'b1;
    wait_h2(1'b1, lat);
    if (lat > max_lat) max_lat = lat;
    bus.uP_handshake_1 = 1'b0;
    wait_h2(1'b0, lat);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int lat;
    bus.uP_handshake_1 = 1'b1;
    wait_h2(1'b1, lat);
    b = bus.uP_data_in;
    bus.uP_handshake_1 = 1'b0;
    wait_h2(1'b0, lat);
  endtask

  task automatic begin_packet();
    bus.uP_start = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_packet(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] wdata);
    logic [7:0]  exp_status;
    logic [7:0]  b;
    logic [31:0] got;
    logic        good;
    int          wc0, rc0, n;
    exp_status = (cmd != 8'd1 && cmd != 8'd2) ? 8'h01 : (addr >= NOS) ? 8'h02 : 8'h00;
    good = (exp_status == 8'h00);
    wc0 = wr_count;
    rc0 = rd_count;
    got = 32'h0;
    begin_packet();
    send_byte(cmd);
    send_byte(addr);
    if (cmd == 8'd2) begin
      for (int i = 0; i < 4; i++) begin
        recv_byte(b);
        got = got | (32'(b) << (8 * i));
      end
    end else begin
      for (int i = 0; i < 4; i++) send_byte(8'((wdata >> (8 * i)) & 32'hFF));
    end
    n = 0;
    while (bus.uP_ack !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ack_high", 32'(bus.uP_ack), 32'd1);
    check("status", 32'(bus.uP_data_in), 32'(exp_status));
    if (cmd == 8'd1 && good) exp_mem[addr] = wdata;
    check("write_strobes", 32'(wr_count - wc0), (cmd == 8'd1 && good) ? 32'd1 : 32'd0);
    check("read_strobes", 32'(rd_count - rc0), (cmd == 8'd2 && good) ? 32'd1 : 32'd0);
    if (cmd == 8'd1 && good) begin
      check("write_addr", 32'(last_wr_addr), 32'(addr));
      check("write_data", last_wr_data, wdata);
    end
    if (cmd == 8'd2) check("read_data", got, good ? exp_mem[addr] : 32'h0);
    bus.uP_start = 1'b0;
    repeat (3) @(negedge clk);
    check("ack_clear", 32'(bus.uP_ack), 32'd0);
    check("data_in_clear", 32'(bus.uP_data_in), 32'd0);
    $display("pkt %0d cmd=%02h addr=%0d status=%02h wdata=%08h rdata=%08h", pkt_no, cmd, addr,
             exp_status, wdata, got);
    pkt_no++;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_h2"},     32'(bus.uP_handshake_2), 32'd0);
    check({tag, "_din"},    32'(bus.uP_data_in), 32'd0);
    check({tag, "_ack"},    32'(bus.uP_ack), 32'd0);
    check({tag, "_addr"},   32'(bus.reg_address), 32'd0);
    check({tag, "_wdata"},  bus.reg_write_data, 32'd0);
    check({tag, "_wr"},     32'(bus.reg_write), 32'd0);
    check({tag, "_rd"},     32'(bus.reg_read), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] cmd, addr;
    int wc0, lat;
    for (int i = 0; i < 256; i++) exp_mem[i] = (i == 5) ? 32'h12345678 : 32'h0;
    bus.uP_start       = 1'b0;
    bus.uP_handshake_1 = 1'b0;
    bus.uP_data_out    = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_packet(8'h01, 8'd3, 32'h0000002A);
    run_packet(8'h02, 8'd5, 32'h0);
    run_packet(8'h07, 8'd4, 32'hDEADBEEF);
    run_packet(8'h01, 8'd40, 32'h11223344);

    // Abort after the second data byte, then a good write must still work.
    wc0 = wr_count;
    begin_packet();
    send_byte(8'h01);
    send_byte(8'd3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.uP_start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_h2", 32'(bus.uP_handshake_2), 32'd0);
    check("abort_ack", 32'(bus.uP_ack), 32'd0);
    check("abort_no_write", 32'(wr_count - wc0), 32'd0);
    $display("pkt %0d aborted write after 2 data bytes", pkt_no);
    pkt_no++;
    run_packet(8'h01, 8'd3, 32'hCAFE0103);

    // Reset while the third read byte is being handed out.
    begin_packet();
    send_byte(8'h02);
    send_byte(8'd5);
    recv_byte(b);
    recv_byte(b);
    bus.uP_handshake_1 = 1'b1;
    wait_h2(1'b1, lat);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midread_reset");
    reset = 1'b0;
    bus.uP_handshake_1 = 1'b0;
    bus.uP_start = 1'b0;
    repeat (4) @(negedge clk);
    $display("pkt %0d read interrupted by reset", pkt_no);
    pkt_no++;
    run_packet(8'h02, 8'd5, 32'h0);

    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 4))
        0, 1:    cmd = 8'h01;
        2, 3:    cmd = 8'h02;
        default: cmd = 8'($urandom_range(3, 255));
      endcase
      addr = 8'($urandom_range(0, 11));
      if (addr > 8'd7) addr = addr + 8'd24;
      run_packet(cmd, addr, $urandom);
    end
    run_packet(8'h02, 8'd3, 32'h0);

    check("inbound_latency_ok", 32'(max_lat <= SYNC + 1), 32'd1);
    check("strobe_overlap", 32'(both_high), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
